timer_mc: RTL and testbench

- Multi-channel, parametrised successor to the single timer core.
- Provides NUM_CH independent down-counting timers, each with:
  - its own prescaler
  - one-shot or periodic mode
  - a sticky "reached" flag
- Offers synchronous group start and a combined level interrupt.
- Sits on the application FPGA memory-mapped bus (cs/we/address/write_data, single-cycle ready), like other cores.

---
 rtl/timer_mc.sv | 226 ++++++++++++++++++++++
 tb/tb_timer_mc.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_mc.sv
// timer_mc: NUM_CH independent prescaled down-counting timers on a single-cycle memory-mapped bus.
// Optional snapshot registers (write 8'h0A, read channel offset +6) are built only with `TIMER_MC_SNAPSHOT_EN.
module timer_mc #(
  parameter int NUM_CH          = 4,
  parameter int TIMER_WIDTH     = 32,
  parameter int PRESCALER_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        irq
);

  localparam int TW = TIMER_WIDTH;
  localparam int PW = PRESCALER_WIDTH;

  localparam logic [7:0] ADDR_IRQ_STATUS = 8'h08;
  localparam logic [7:0] ADDR_GROUP      = 8'h09;
  localparam logic [7:0] ADDR_CH_FIRST   = 8'h10;
  localparam logic [7:0] ADDR_CH_END     = 8'h50;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_CONFIG = 3'd1;
  localparam logic [2:0] OFF_STATUS = 3'd2;
  localparam logic [2:0] OFF_PRESC  = 3'd3;
  localparam logic [2:0] OFF_TIMER  = 3'd4;
  localparam logic [2:0] OFF_CURR   = 3'd5;
  localparam logic [2:0] OFF_SNAP   = 3'd6;

  // A programmed prescaler of zero behaves like one.
  function automatic logic [PW-1:0] eff_presc(input logic [PW-1:0] p);
    if (p == '0) begin
      eff_presc = PW'(1);
    end else begin
      eff_presc = p;
    end
  endfunction

  logic [NUM_CH-1:0] running_q, running_d;
  logic [NUM_CH-1:0] reached_q, reached_d;
  logic [NUM_CH-1:0] periodic_q, periodic_d;
  logic [NUM_CH-1:0] irq_en_q, irq_en_d;
  logic [TW-1:0]     curr_q  [NUM_CH];
  logic [TW-1:0]     curr_d  [NUM_CH];
  logic [TW-1:0]     timer_q [NUM_CH];
  logic [TW-1:0]     timer_d [NUM_CH];
  logic [PW-1:0]     pcnt_q  [NUM_CH];
  logic [PW-1:0]     pcnt_d  [NUM_CH];
  logic [PW-1:0]     presc_q [NUM_CH];
  logic [PW-1:0]     presc_d [NUM_CH];
  logic              irq_q;

  logic              wr_s;
  logic              ch_space_s;
  logic [2:0]        ch_idx_s;
  logic [2:0]        reg_off_s;
  logic [NUM_CH-1:0] ch_sel_s;
  logic [NUM_CH-1:0] start_s;
  logic [NUM_CH-1:0] stop_s;
  logic [NUM_CH-1:0] clear_s;
  logic [NUM_CH-1:0] tc_s;
  logic [NUM_CH-1:0] irq_status_s;
  logic [31:0]       ch_rd_s [NUM_CH];

  assign wr_s         = cs & we;
  assign ch_space_s   = (address >= ADDR_CH_FIRST) && (address < ADDR_CH_END);
  // Channel blocks are 8 words starting at 8'h10, so the index is address[5:3] offset by two.
  assign ch_idx_s     = address[5:3] - 3'd2;
  assign reg_off_s    = address[2:0];
  assign irq_status_s = reached_q & irq_en_q;
  assign ready        = cs;
  assign irq          = irq_q;

  // Decode the current bus write into per-channel select and command strobes.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_sel_s[c] = ch_space_s && (ch_idx_s == 3'(c));
      start_s[c]  = (wr_s && ch_sel_s[c] && (reg_off_s == OFF_CTRL) && write_data[0])
                 || (wr_s && (address == ADDR_GROUP) && write_data[c]);
      stop_s[c]   = wr_s && ch_sel_s[c] && (reg_off_s == OFF_CTRL) && write_data[1];
      clear_s[c]  = wr_s && ch_sel_s[c] && (reg_off_s == OFF_CTRL) && write_data[2];
    end
  end

  // Channel next-state: counting, terminal count, start/stop and idle-only register writes.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      running_d[c]  = running_q[c];
      reached_d[c]  = reached_q[c];
      periodic_d[c] = periodic_q[c];
      irq_en_d[c]   = irq_en_q[c];
      curr_d[c]     = curr_q[c];
      timer_d[c]    = timer_q[c];
      pcnt_d[c]     = pcnt_q[c];
      presc_d[c]    = presc_q[c];
      tc_s[c]       = running_q[c] && (pcnt_q[c] <= PW'(1)) && (curr_q[c] == TW'(1));

      if (running_q[c]) begin
        // A stop freezes the counters; a coincident terminal count still sets reached.
        if (stop_s[c]) begin
          running_d[c] = 1'b0;
        end else if (pcnt_q[c] > PW'(1)) begin
          pcnt_d[c] = pcnt_q[c] - PW'(1);
        end else begin
          pcnt_d[c] = eff_presc(presc_q[c]);
          if (tc_s[c]) begin
            if (periodic_q[c]) begin
              curr_d[c] = timer_q[c];
            end else begin
              curr_d[c]    = '0;
              running_d[c] = 1'b0;
            end
          end else begin
            curr_d[c] = curr_q[c] - TW'(1);
          end
        end
        reached_d[c] = (reached_q[c] & ~clear_s[c]) | tc_s[c];
      end else begin
        if (start_s[c] && !stop_s[c] && (timer_q[c] != '0)) begin
          pcnt_d[c]    = eff_presc(presc_q[c]);
          curr_d[c]    = timer_q[c];
          running_d[c] = 1'b1;
          reached_d[c] = 1'b0;
        end else begin
          reached_d[c] = reached_q[c] & ~clear_s[c];
        end

        if (wr_s && ch_sel_s[c]) begin
          case (reg_off_s)
            OFF_CONFIG: begin
              periodic_d[c] = write_data[0];
              irq_en_d[c]   = write_data[1];
            end
            OFF_PRESC: presc_d[c] = write_data[PW-1:0];
            OFF_TIMER: timer_d[c] = write_data[TW-1:0];
            default: begin
              presc_d[c] = presc_q[c];
            end
          endcase
        end else begin
          timer_d[c] = timer_q[c];
        end
      end
    end
  end

  // Channel state and interrupt registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running_q  <= '0;
      reached_q  <= '0;
      periodic_q <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        curr_q[c]  <= '0;
        pcnt_q[c]  <= '0;
        timer_q[c] <= TW'(1);
        presc_q[c] <= PW'(1);
      end
    end else begin
      running_q  <= running_d;
      reached_q  <= reached_d;
      periodic_q <= periodic_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= |irq_status_s;
      curr_q     <= curr_d;
      pcnt_q     <= pcnt_d;
      timer_q    <= timer_d;
      presc_q    <= presc_d;
    end
  end

`ifdef TIMER_MC_SNAPSHOT_EN
  localparam logic [7:0] ADDR_SNAP = 8'h0A;
  logic [TW-1:0] snap_q [NUM_CH];

  // All channels capture their live count on the same edge for a coherent view.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        snap_q[c] <= '0;
      end
    end else if (wr_s && (address == ADDR_SNAP)) begin
      snap_q <= curr_q;
    end
  end
`endif

  // Per-channel readback value for the addressed offset.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      case (reg_off_s)
        OFF_CONFIG: ch_rd_s[c] = {30'h0, irq_en_q[c], periodic_q[c]};
        OFF_STATUS: ch_rd_s[c] = {30'h0, reached_q[c], running_q[c]};
        OFF_PRESC:  ch_rd_s[c] = 32'(presc_q[c]);
        OFF_TIMER:  ch_rd_s[c] = 32'(timer_q[c]);
        OFF_CURR:   ch_rd_s[c] = 32'(curr_q[c]);
`ifdef TIMER_MC_SNAPSHOT_EN
        OFF_SNAP:   ch_rd_s[c] = 32'(snap_q[c]);
`endif
        default:    ch_rd_s[c] = 32'h0;
      endcase
    end
  end

  // Combinational read mux; anything not mapped reads zero.
  always_comb begin
    read_data = 32'h0;
    if (cs && (address == ADDR_IRQ_STATUS)) begin
      read_data = 32'(irq_status_s);
    end else if (cs) begin
      for (int c = 0; c < NUM_CH; c++) begin
        read_data = read_data | (ch_sel_s[c] ? ch_rd_s[c] : 32'h0);
      end
    end else begin
      read_data = 32'h0;
    end
  end

endmodule

// File: tb/tb_timer_mc.sv
// Randomized self-checking bench for timer_mc against an elapsed-time reference model.
module tb_timer_mc;

  localparam int NUM_CH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        irq;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_rd;

  timer_mc #(.NUM_CH(NUM_CH), .TIMER_WIDTH(32), .PRESCALER_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: each channel remembers how many edges it has counted since its load.
  bit     m_run [NUM_CH];
  bit     m_reach [NUM_CH];
  bit     m_per [NUM_CH];
  bit     m_ien [NUM_CH];
  bit     m_loaded [NUM_CH];
  bit     m_lper [NUM_CH];
  longint m_presc [NUM_CH];
  longint m_timer [NUM_CH];
  longint m_el [NUM_CH];
  longint m_lp [NUM_CH];
  longint m_lt [NUM_CH];
  longint m_snap [NUM_CH];
  bit     m_irq;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = 0; m_reach[c] = 0; m_per[c] = 0; m_ien[c] = 0;
      m_loaded[c] = 0; m_lper[c] = 0; m_presc[c] = 1; m_timer[c] = 1;
      m_el[c] = 0; m_lp[c] = 1; m_lt[c] = 1; m_snap[c] = 0;
    end
    m_irq = 0;
  endfunction

  function automatic longint model_curr(input int c);
    longint d;
    if (!m_loaded[c]) return 0;
    d = m_el[c] / m_lp[c];
    if (m_lper[c]) return m_lt[c] - (d % m_lt[c]);
    return m_lt[c] - d;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int c;
    logic [31:0] v;
    if (a == 8'h08) begin
      v = 32'h0;
      for (int k = 0; k < NUM_CH; k++) v[k] = m_reach[k] && m_ien[k];
      return v;
    end
    if (a < 8'h10 || a >= 8'h50) return 32'h0;
    c = (int'(a) - 16) / 8;
    if (c >= NUM_CH) return 32'h0;
    case (int'(a[2:0]))
      1: return {30'h0, m_ien[c], m_per[c]};
      2: return {30'h0, m_reach[c], m_run[c]};
      3: return 32'(m_presc[c]);
      4: return 32'(m_timer[c]);
      5: return 32'(model_curr(c));
`ifdef TIMER_MC_SNAPSHOT_EN
      6: return 32'(m_snap[c]);
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_step(input bit wr, input logic [7:0] a, input logic [31:0] d);
    bit irq_n;
    bit in_ch, start, stop, clr, was_run, tc;
    longint period;
    irq_n = 0;
    for (int c = 0; c < NUM_CH; c++) irq_n = irq_n | (m_reach[c] && m_ien[c]);
`ifdef TIMER_MC_SNAPSHOT_EN
    if (wr && a == 8'h0A) begin
      for (int c = 0; c < NUM_CH; c++) m_snap[c] = model_curr(c);
    end
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      in_ch   = wr && a >= 8'h10 && a < 8'h50 && ((int'(a) - 16) / 8 == c);
      start   = (in_ch && a[2:0] == 3'd0 && d[0]) || (wr && a == 8'h09 && d[c]);
      stop    = in_ch && a[2:0] == 3'd0 && d[1];
      clr     = in_ch && a[2:0] == 3'd0 && d[2];
      was_run = m_run[c];
      tc      = 0;
      if (was_run) begin
        period = m_lp[c] * m_lt[c];
        if (stop) begin
          m_run[c] = 0;
          tc = ((m_el[c] + 1) % period == 0);
        end else begin
          m_el[c]++;
          if (m_el[c] % period == 0) begin
            tc = 1;
            if (!m_lper[c]) m_run[c] = 0;
          end
        end
      end
      m_reach[c] = (m_reach[c] && !clr) || tc;
      if (!was_run && start && !stop && m_timer[c] != 0) begin
        m_run[c] = 1; m_reach[c] = 0; m_el[c] = 0; m_loaded[c] = 1;
        m_lp[c] = (m_presc[c] == 0) ? 1 : m_presc[c];
        m_lt[c] = m_timer[c];
        m_lper[c] = m_per[c];
      end
      if (!was_run && in_ch) begin
        case (int'(a[2:0]))
          1: begin m_per[c] = d[0]; m_ien[c] = d[1]; end
          3: m_presc[c] = longint'(d);
          4: m_timer[c] = longint'(d);
          default: ;
        endcase
      end
    end
    m_irq = irq_n;
  endfunction

  // One bus cycle: drive at negedge, check outputs against the model, then advance the model.
  task automatic bus_cycle(input logic c, input logic w, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = c; we = w; address = a; write_data = d;
    #1;
    last_rd = read_data;
    check_val("irq", 32'(irq), 32'(m_irq));
    check_val("ready", 32'(ready), 32'(c));
    if (c && !w) check_val($sformatf("read_%02h", a), read_data, model_read(a));
    if (!c) check_val("read_idle", read_data, 32'h0);
    @(posedge clk);
    model_step(c && w, a, d);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus_cycle(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [7:0] a);
    bus_cycle(1'b1, 1'b0, a, 32'h0);
  endtask

  function automatic logic [7:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 8'(16 + 8 * $urandom_range(0, NUM_CH - 1) + $urandom_range(0, 7));
    if (r < 9) return 8'(8 + $urandom_range(0, 2));
    return 8'($urandom_range(0, 255));
  endfunction

  function automatic logic [31:0] rand_data(input logic [7:0] a);
    logic [31:0] v;
    if (a == 8'h09) return $urandom & 32'hFF;
    if (a >= 8'h10 && a[2:0] == 3'd0) begin
      v = 32'h0;
      v[0] = 1'($urandom_range(0, 1));
      v[1] = ($urandom_range(0, 7) == 0);
      v[2] = ($urandom_range(0, 3) == 0);
      return v;
    end
    if (a[2:0] == 3'd3 || a[2:0] == 3'd4) return 32'($urandom_range(0, 5));
    return $urandom;
  endfunction

  initial begin
    int edges;
    logic [7:0] a;
    reset_n = 1'b0; cs = 1'b0; we = 1'b0; address = 8'h0; write_data = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_val("rst_irq", 32'(irq), 32'h0);
    check_val("rst_rdata", read_data, 32'h0);
    reset_n = 1'b1;

    for (int c = 0; c < NUM_CH; c++) begin
      for (int o = 1; o <= 6; o++) rd(8'(16 + 8 * c + o));
    end
    rd(8'h13);
    check_val("rst_presc", last_rd, 32'h1);

    // Ch0 one-shot, P=3 T=4: reached and idle 12 edges after load.
    wr(8'h13, 32'd3); wr(8'h14, 32'd4); wr(8'h11, 32'd0); wr(8'h10, 32'd1);
    edges = -1;
    for (int k = 1; k <= 20; k++) begin
      rd(8'h12);
      if (edges < 0 && last_rd[1]) begin
        edges = k - 1;
        check_val("ch0_done_status", last_rd, 32'h2);
      end
    end
    check_val("ch0_edges", 32'(edges), 32'd12);
    rd(8'h15);
    check_val("ch0_curr_zero", last_rd, 32'h0);

    // Ch1 periodic with irq, P=1 T=5; then clear reached and stop.
    wr(8'h1B, 32'd1); wr(8'h1C, 32'd5); wr(8'h19, 32'd3); wr(8'h18, 32'd1);
    for (int k = 0; k < 12; k++) rd(8'h1D);
    wr(8'h18, 32'd4);
    for (int k = 0; k < 3; k++) rd(8'h08);
    wr(8'h18, 32'd2);

    // Group start of ch0 and ch2 with identical configs.
    wr(8'h13, 32'd2); wr(8'h14, 32'd6); wr(8'h11, 32'd1);
    wr(8'h23, 32'd2); wr(8'h24, 32'd6); wr(8'h21, 32'd1);
    wr(8'h09, 32'h5);
    for (int k = 0; k < 8; k++) begin
      rd(8'h15); rd(8'h25);
    end
    rd(8'h1A); rd(8'h32);
    wr(8'h14, 32'd9); rd(8'h14);
    check_val("locked_timer", last_rd, 32'd6);
    wr(8'h30, 32'd3); rd(8'h32);
    wr(8'h34, 32'd0); wr(8'h30, 32'd1); rd(8'h32); rd(8'h35);
    wr(8'h10, 32'd2); wr(8'h20, 32'd2);

`ifdef TIMER_MC_SNAPSHOT_EN
    wr(8'h14, 32'd50); wr(8'h13, 32'd1); wr(8'h10, 32'd1);
    wr(8'h1C, 32'd40); wr(8'h1B, 32'd2); wr(8'h18, 32'd1);
    rd(8'h15); rd(8'h1D);
    wr(8'h0A, 32'h0);
    for (int k = 0; k < 3; k++) begin
      rd(8'h16); rd(8'h1E);
    end
    wr(8'h10, 32'd2); wr(8'h18, 32'd2);
`endif

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      a = rand_addr();
      bus_cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), a, rand_data(a));
    end
    for (int c = 0; c < NUM_CH; c++) wr(8'(16 + 8 * c), 32'd2);

    // Reset in the middle of a count with irq pending.
    wr(8'h14, 32'd100); wr(8'h13, 32'd1); wr(8'h10, 32'd1);
    wr(8'h1B, 32'd1); wr(8'h1C, 32'd2); wr(8'h19, 32'd3); wr(8'h18, 32'd1);
    for (int k = 0; k < 6; k++) rd(8'h12);
    check_val("pre_rst_irq", 32'(irq), 32'h1);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; address = 8'h12; write_data = 32'h0;
    #1;
    check_val("pre_rst_status", read_data, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_rst_irq", 32'(irq), 32'h0);
    check_val("async_rst_rdata", read_data, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rd(8'h13);
    check_val("post_rst_presc", last_rd, 32'h1);
    rd(8'h14);
    check_val("post_rst_timer", last_rd, 32'h1);
    rd(8'h12); rd(8'h15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
